// File: rtl/rom_byte_streamer.sv
// rom_byte_streamer: walks a run of consecutive ROM addresses, absorbs the ROM
// read latency with a flag pipe, and buffers the returned bytes in a small FIFO
// that drains through a valid/ready stream. Issue is credit-limited so the FIFO
// can never overflow, whatever the downstream back-pressure.
module rom_byte_streamer #(
   parameter int ADDR_W     = 20,
   parameter int DATA_W     = 8,
   parameter int ROM_LAT    = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] length,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] address_20bits,
   input  logic [DATA_W-1:0] q_8bits,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   // wide enough for fifo_count + in_flight without overflow
   localparam int SUM_W = $clog2(FIFO_DEPTH + ROM_LAT + 2);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_DONE
   } state_t;

   state_t              state_reg, state_next;
   logic [ADDR_W-1:0]   addr_reg;
   logic [ADDR_W-1:0]   remain_reg;
   logic [ROM_LAT-1:0]  pipe_reg;
   logic                done_reg;

   logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0]    count_reg;

   logic [SUM_W-1:0]    inflight;
   logic                credit_ok;
   logic                accept;
   logic                issue;
   logic                push;
   logic                pop;

   assign push           = pipe_reg[ROM_LAT-1];
   assign out_valid      = (count_reg != '0);
   assign pop            = out_valid && out_ready;
   assign out_data       = fifo_mem[rd_ptr_reg];
   assign address_20bits = addr_reg;
   assign done           = done_reg;

   // count outstanding ROM reads; a popping byte is still counted in count_reg
   always_comb begin
      inflight = '0;
      for (int i = 0; i < ROM_LAT; i++) begin
         inflight = inflight + SUM_W'(pipe_reg[i]);
      end
      credit_ok = (SUM_W'(count_reg) + inflight) < SUM_W'(FIFO_DEPTH);
   end

   // next-state logic and control strobes
   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      issue      = 1'b0;
      busy       = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = (length == '0) ? ST_DONE : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            busy = 1'b1;
            if (credit_ok) begin
               issue = 1'b1;
               if (remain_reg == ADDR_W'(1)) begin
                  state_next = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            busy = 1'b1;
            // finish on the edge that accepts the final byte
            if (inflight == '0 &&
                (count_reg == '0 || (count_reg == CNT_W'(1) && pop))) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // one-cycle completion pulse following the DONE state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done_reg <= 1'b0;
      end else begin
         done_reg <= (state_reg == ST_DONE);
      end
   end

   // address walker; the address is left on the last issued byte
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_reg   <= '0;
         remain_reg <= '0;
      end else if (accept) begin
         addr_reg   <= base_addr;
         remain_reg <= length;
      end else if (issue) begin
         remain_reg <= remain_reg - ADDR_W'(1);
         if (remain_reg != ADDR_W'(1)) begin
            addr_reg <= addr_reg + ADDR_W'(1);
         end
      end
   end

   // issue-flag pipe matching the ROM read latency
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pipe_reg <= '0;
      end else begin
         pipe_reg[0] <= issue;
         for (int i = 1; i < ROM_LAT; i++) begin
            pipe_reg[i] <= pipe_reg[i-1];
         end
      end
   end

   // output FIFO: write ROM data as flags leave the pipe, read on handshake
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem[i] <= '0;
         end
      end else begin
         if (push) begin
            fifo_mem[wr_ptr_reg] <= q_8bits;
            wr_ptr_reg           <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
      end
   end

endmodule

// File: tb/tb_rom_byte_streamer.sv
// Randomised bench for rom_byte_streamer with a latency-1 ROM model
// (q = addr[7:0] ^ 0x5A); expected bytes come from the address arithmetic.
`timescale 1ns/1ps
module tb_rom_byte_streamer;

   localparam int ADDR_W     = 20;
   localparam int DATA_W     = 8;
   localparam int ROM_LAT    = 1;
   localparam int FIFO_DEPTH = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic              out_ready = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [ADDR_W-1:0] length = '0;
   logic              busy, done, out_valid;
   logic [ADDR_W-1:0] address_20bits;
   logic [DATA_W-1:0] q_8bits = '0;
   logic [DATA_W-1:0] out_data;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   // synchronous ROM, one cycle of latency
   always @(posedge clk) q_8bits <= address_20bits[7:0] ^ 8'h5A;

   rom_byte_streamer #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
      .busy(busy), .done(done), .address_20bits(address_20bits), .q_8bits(q_8bits),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_busy"}, busy, 1'b0);
      check_eq({tag, "_done"}, done, 1'b0);
      check_eq({tag, "_valid"}, out_valid, 1'b0);
      check_eq({tag, "_addr"}, address_20bits, 32'h0);
      check_eq({tag, "_data"}, out_data, 32'h0);
   endtask

   // mode: 0 always ready, 1 ready pattern 1,0,0, 2 random ready
   // mid_start: cycle at which a stray start is pulsed (-1 = none)
   // abort_hs: assert reset after this many handshakes (0 = never)
   task automatic run_xfer(input logic [ADDR_W-1:0] b, input int n, input int mode,
                           input int mid_start, input int abort_hs, input bit timed);
      logic [DATA_W-1:0] exp_q[$];
      logic [ADDR_W-1:0] addr_q[$];
      logic [ADDR_W-1:0] a, last_addr, ahead;
      logic [DATA_W-1:0] prev_data;
      bit prev_stall, seen_addr;
      int cyc, hs, dones, first_valid, first_hs, last_hs, done_cyc;
      for (int i = 0; i < n; i++) begin
         a = b + ADDR_W'(i);
         exp_q.push_back(a[7:0] ^ 8'h5A);
         addr_q.push_back(a);
      end
      @(negedge clk);
      start = 1'b1; base_addr = b; length = ADDR_W'(n); out_ready = 1'b0;
      @(negedge clk);
      start = 1'b0; base_addr = ADDR_W'($urandom); length = ADDR_W'($urandom);
      cyc = 0; hs = 0; dones = 0; first_valid = -1; first_hs = -1; last_hs = -1;
      done_cyc = -1; prev_stall = 0; seen_addr = 0; prev_data = '0; last_addr = '0;
      check_eq("busy_after_start", busy, n != 0);
      while (cyc < 300 && !(dones > 0 && cyc > done_cyc + 2)) begin
         if (abort_hs > 0 && hs == abort_hs) begin
            rst = 1'b0;
            #1;
            check_reset_outputs("abort");
            $display("xfer base=0x%05h len=%0d aborted by reset after %0d bytes", b, n, hs);
            return;
         end
         start = (cyc == mid_start);
         if (start) begin
            base_addr = ADDR_W'($urandom);
            length = ADDR_W'($urandom_range(1, 9));
         end
         case (mode)
            0: out_ready = 1'b1;
            1: out_ready = (cyc % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         if (busy) begin
            if (!seen_addr || address_20bits != last_addr) begin
               if (addr_q.size() == 0) check_eq("addr_seq_len", address_20bits, last_addr);
               else check_eq("addr_seq", address_20bits, addr_q.pop_front());
               seen_addr = 1;
               last_addr = address_20bits;
            end
            ahead = address_20bits - b;
            check_eq("addr_ahead_le_depth", (int'(ahead) - hs) <= FIFO_DEPTH, 1'b1);
         end
         if (prev_stall) begin
            check_eq("stall_valid_hold", out_valid, 1'b1);
            check_eq("stall_data_hold", out_data, prev_data);
         end
         if (out_valid && first_valid < 0) first_valid = cyc;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check_eq("byte_count", hs + 1, n);
            else check_eq("byte", out_data, exp_q.pop_front());
            hs++;
            if (first_hs < 0) first_hs = cyc + 1;
            last_hs = cyc + 1;
         end
         prev_stall = out_valid && !out_ready;
         prev_data = out_data;
         if (done) begin
            dones++;
            if (dones == 1) done_cyc = cyc;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      out_ready = 1'b0;
      check_eq("done_count", dones, 1);
      check_eq("bytes_left", exp_q.size(), 0);
      check_eq("addr_left", addr_q.size(), 0);
      if (n > 0) begin
         check_eq("done_after_last_hs", done_cyc, last_hs + 1);
      end else begin
         check_eq("zero_done_cycle", done_cyc, 1);
         check_eq("zero_no_valid", first_valid, -1);
      end
      if (timed) begin
         check_eq("first_valid_cycle", first_valid, 2);
         check_eq("stream_span", last_hs - first_hs, n - 1);
      end
      $display("xfer base=0x%05h len=%0d mode=%0d bytes=%0d dones=%0d", b, n, mode, hs, dones);
   endtask

   initial begin
      // reset held with start asserted
      rst = 1'b0; start = 1'b1; base_addr = 20'h12345; length = 20'd7; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      start = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("idle_busy", busy, 1'b0);
      check_eq("idle_valid", out_valid, 1'b0);
      check_eq("idle_done", done, 1'b0);

      run_xfer(20'h0000C, 4, 0, -1, 0, 1'b1);
      run_xfer(20'h000AC, 8, 1, -1, 0, 1'b0);
      run_xfer(20'hFFFFE, 4, 0, -1, 0, 1'b0);
      run_xfer(20'h00000, 0, 0, -1, 0, 1'b0);
      run_xfer(20'h004A9, 3, 0, 1, 0, 1'b0);
      run_xfer(20'h01F88, 16, 0, -1, 5, 1'b0);
      repeat (2) @(negedge clk);
      check_reset_outputs("held_reset");
      rst = 1'b1;
      @(negedge clk);
      run_xfer(20'h00000, 2, 0, -1, 0, 1'b0);

      for (int t = 0; t < 12; t++) begin
         logic [ADDR_W-1:0] rb;
         rb = (t % 3 == 0) ? (20'hFFFF0 + ADDR_W'($urandom_range(0, 15))) : ADDR_W'($urandom);
         run_xfer(rb, $urandom_range(0, 20), $urandom_range(0, 2), -1, 0, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
      $fatal(1, "watchdog expired");
   end

endmodule
